pll_reset_seq: RTL
==================

Name: pll_reset_seq

Overview:
Sequences the ECP5 EHXPLLL that generates the 50 MHz core clock from the 12 MHz board clock. The block runs on the 12 MHz reference clock, so it stays alive while the PLL is down. It drives the PLL RST/STDBY pins, qualifies the asynchronous LOCK signal, and holds the core reset until lock has been stable for a programmed time. It retries on lock timeout, declares a sticky failure after MAX_RETRIES, and re-sequences on lock loss.

Parameters:
POR_CYCLES, 16, cycles pll_rst is held high on each (re)start; minimum 1
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry
STABLE_CYCLES, 256, cycles lock_s must stay high before core reset is released
MAX_RETRIES, 3, PLL restarts allowed before FAIL
CNT_W, 16, shared cycle counter width; must hold max(POR_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
clk  in  1  reference clock (12 MHz board clock, same net as the PLL CLKI)
rst  in  1  synchronous, active-high reset
pll_lock  in  1  PLL LOCK output, asynchronous to clk
sleep_req  in  1  level request to place the PLL in standby
pll_rst  out  1  drives EHXPLLL RST
pll_stdby  out  1  drives EHXPLLL STDBY
sys_rst  out  1  active-high core reset request; the core domain re-synchronizes it
ready  out  1  PLL locked and stable, core released
fail  out  1  sticky: lock never achieved within retry budget
retry_cnt  out  2  restarts used in the current sequence (saturates at MAX_RETRIES)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on posedge clk.
- Reset values: state=RESET_PLL, cnt=0, pll_rst=1, pll_stdby=0, sys_rst=1, ready=0, fail=0, retry_cnt=0.
- rst asserted in any state, including mid-sequence or in FAIL, restores the reset values on the next edge.
- pll_lock passes through a 2-flop synchronizer to produce lock_s; the synchronizer flops reset to 0.
- All outputs are registered and a function of the registered state (Moore outputs). A transition at edge n changes the outputs at edge n.
- RESET_PLL:
  - pll_rst=1, sys_rst=1, ready=0.
  - cnt counts 0..POR_CYCLES-1, then the state moves to WAIT_LOCK with cnt=0.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1, go to STABLE with cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRIES, go to FAIL;
    - otherwise increment retry_cnt and go to RESET_PLL with cnt=0.
  - Else cnt increments.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK with cnt=0; retry_cnt is unchanged.
  - Else if cnt==STABLE_CYCLES-1, go to RUN.
  - Else cnt increments.
- RUN:
  - sys_rst=0, ready=1.
  - lock_s=0 takes priority over sleep_req: go to RESET_PLL with cnt=0 and clear retry_cnt.
- STANDBY:
  - pll_stdby=1, pll_rst=0, sys_rst=1, ready=0.
  - When sleep_req=0, go to RESET_PLL with retry_cnt=0.
- FAIL:
  - pll_rst=1, sys_rst=1, fail=1, ready=0.
  - Exit only through rst.
- Boundary rules:
  - LOCK_TIMEOUT is counted from entry to WAIT_LOCK; re-entry from STABLE restarts the timeout.
  - A lock glitch shorter than one clk may be missed; that is acceptable.
- Latency: when the first synchronizer flop samples lock=1 at edge e and lock stays high, ready rises at edge e+2+STABLE_CYCLES.

Optional Feature:
Macro PLL_SEQ_STANDBY_EN.
- Defined: the STANDBY state and sleep_req are implemented. RUN with sleep_req=1 and lock_s=1 moves to STANDBY.
- Undefined: there is no STANDBY state, sleep_req is ignored and pll_stdby is tied to 0.

Test Plan:
Bench parameters: POR_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal lock: release rst; pll_lock rises 10 cycles later and stays high -> pll_rst low 4 cycles after reset release; ready=1 and sys_rst=0 exactly 10 edges after lock is first sampled; retry_cnt=0, fail=0.
2. Never lock: pll_lock held at 0 -> three pll_rst pulses of 4 cycles (initial plus 2 retries) separated by 20-cycle waits; then fail=1, pll_rst=1, retry_cnt=2 permanently until rst.
3. Glitch during STABLE: lock high 5 cycles, low 3 cycles, then high -> ready stays 0 through the glitch; state returns to WAIT_LOCK with retry_cnt unchanged; ready rises 10 edges after lock is sampled high again.
4. Lock loss in RUN: drop pll_lock for 4 cycles -> sys_rst=1 and ready=0 within 3 edges; pll_rst=1 for 4 cycles; retry_cnt=0; normal re-lock follows.
5. Standby (macro defined): in RUN assert sleep_req for 30 cycles -> pll_stdby=1 and sys_rst=1 next edge; on deassert, pll_stdby=0 and a 4-cycle pll_rst pulse starts a fresh sequence. With the macro undefined, sleep_req has no effect.
6. Reset mid-operation: assert rst for 1 cycle at WAIT_LOCK cnt=12 -> next edge shows pll_rst=1, sys_rst=1, cnt=0, retry_cnt=0; the full sequence restarts.

Source files
------------

// File: rtl/pll_reset_seq_if.sv
// PLL control and core-reset signal bundle for the pll_reset_seq sequencer.
// The master modport is the sequencer; the slave modport is the PLL/core side.
interface pll_reset_seq_if;
  logic       pll_lock;
  logic       sleep_req;
  logic       pll_rst;
  logic       pll_stdby;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;

  modport master (
    input  pll_lock,
    input  sleep_req,
    output pll_rst,
    output pll_stdby,
    output sys_rst,
    output ready,
    output fail,
    output retry_cnt
  );

  modport slave (
    output pll_lock,
    output sleep_req,
    input  pll_rst,
    input  pll_stdby,
    input  sys_rst,
    input  ready,
    input  fail,
    input  retry_cnt
  );
endinterface

// File: rtl/pll_reset_seq.sv
// ECP5 EHXPLLL reset/lock sequencer running on the PLL reference clock.
// Optional standby support is enabled by defining PLL_SEQ_STANDBY_EN.
module pll_reset_seq #(
  parameter int POR_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  pll_reset_seq_if.master io
);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
`ifdef PLL_SEQ_STANDBY_EN
    STANDBY   = 3'd4,
`endif
    FAIL      = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       retry_r;
  logic [1:0]       retry_nxt;
  logic             lock_meta_r;
  logic             lock_sync_r;
  logic             lock_s;
  logic             pll_rst_r;
  logic             pll_stdby_r;
  logic             sys_rst_r;
  logic             ready_r;
  logic             fail_r;
  logic             pll_rst_nxt;
  logic             pll_stdby_nxt;
  logic             sys_rst_nxt;
  logic             ready_nxt;
  logic             fail_nxt;

`ifndef PLL_SEQ_STANDBY_EN
  logic unused_sleep_s;
  assign unused_sleep_s = io.sleep_req;
`endif

  assign lock_s = lock_sync_r;

  // Two-flop synchronizer for the asynchronous PLL LOCK pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= io.pll_lock;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    retry_nxt = retry_r;
    case (state_r)
      RESET_PLL: begin
        if (cnt_r == POR_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt_r == LOCK_LAST) begin
          cnt_nxt = CNT_ZERO;
          if (retry_r == RETRY_MAX) begin
            state_nxt = FAIL;
          end else begin
            state_nxt = RESET_PLL;
            retry_nxt = retry_r + 2'd1;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      STABLE: begin
        // A dropout here restarts the lock timeout without spending a retry.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = RESET_PLL;
          cnt_nxt   = CNT_ZERO;
          retry_nxt = 2'd0;
        end
`ifdef PLL_SEQ_STANDBY_EN
        else if (io.sleep_req) begin
          state_nxt = STANDBY;
          cnt_nxt   = CNT_ZERO;
        end
`endif
        else begin
          state_nxt = RUN;
        end
      end
`ifdef PLL_SEQ_STANDBY_EN
      STANDBY: begin
        if (!io.sleep_req) begin
          state_nxt = RESET_PLL;
          cnt_nxt   = CNT_ZERO;
          retry_nxt = 2'd0;
        end else begin
          state_nxt = STANDBY;
        end
      end
`endif
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = RESET_PLL;
        cnt_nxt   = CNT_ZERO;
        retry_nxt = 2'd0;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track the state register.
  always_comb begin
    pll_rst_nxt   = 1'b1;
    pll_stdby_nxt = 1'b0;
    sys_rst_nxt   = 1'b1;
    ready_nxt     = 1'b0;
    fail_nxt      = 1'b0;
    case (state_nxt)
      RESET_PLL: begin
        pll_rst_nxt = 1'b1;
      end
      WAIT_LOCK, STABLE: begin
        pll_rst_nxt = 1'b0;
      end
      RUN: begin
        pll_rst_nxt = 1'b0;
        sys_rst_nxt = 1'b0;
        ready_nxt   = 1'b1;
      end
`ifdef PLL_SEQ_STANDBY_EN
      STANDBY: begin
        pll_rst_nxt   = 1'b0;
        pll_stdby_nxt = 1'b1;
      end
`endif
      FAIL: begin
        fail_nxt = 1'b1;
      end
      default: begin
        pll_rst_nxt = 1'b1;
      end
    endcase
  end

  // State, counter, retry and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RESET_PLL;
      cnt_r       <= CNT_ZERO;
      retry_r     <= 2'd0;
      pll_rst_r   <= 1'b1;
      pll_stdby_r <= 1'b0;
      sys_rst_r   <= 1'b1;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      retry_r     <= retry_nxt;
      pll_rst_r   <= pll_rst_nxt;
      pll_stdby_r <= pll_stdby_nxt;
      sys_rst_r   <= sys_rst_nxt;
      ready_r     <= ready_nxt;
      fail_r      <= fail_nxt;
    end
  end

  assign io.pll_rst   = pll_rst_r;
  assign io.pll_stdby = pll_stdby_r;
  assign io.sys_rst   = sys_rst_r;
  assign io.ready     = ready_r;
  assign io.fail      = fail_r;
  assign io.retry_cnt = retry_r;

endmodule
